// File: rtl/sa_row_skew_feeder.sv
// Row FIFO feeding a systolic array west edge with a diagonal skew:
// lane i sees each row i array-advance steps after lane 0.

module sa_lane_delay #(
  parameter int DW     = 8,
  parameter int STAGES = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] din,
  input  logic          vin,
  output logic [DW-1:0] dout,
  output logic          vout
);
  logic [STAGES-1:0][DW-1:0] dat_pipe;
  logic [STAGES-1:0]         vld_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dat_pipe <= '0;
      vld_pipe <= '0;
    end else if (en) begin
      dat_pipe[0] <= din;
      vld_pipe[0] <= vin;
      for (int s = 1; s < STAGES; s++) begin
        dat_pipe[s] <= dat_pipe[s-1];
        vld_pipe[s] <= vld_pipe[s-1];
      end
    end
  end

  assign dout = dat_pipe[STAGES-1];
  assign vout = vld_pipe[STAGES-1];
endmodule

module sa_row_skew_feeder #(
  parameter int N     = 4,
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] in_data,
  input  logic            in_last,
  input  logic            en,
  output logic [N*DW-1:0] out_data,
  output logic [N-1:0]    out_valid,
  output logic            busy,
  output logic            done,
  output logic [15:0]     underrun
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef struct packed {
    logic                 last;
    logic [N-1:0][DW-1:0] data;
  } row_t;

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

  row_t                 mem [DEPTH];
  row_t                 head;
  logic [AW:0]          wptr, rptr;
  logic                 full, empty, push, pop, shift, under_inc;
  state_t               state_q, state_d;
  logic [CW-1:0]        flush_q, flush_d;
  logic [N-1:0][DW-1:0] inj_data;
  logic [N-1:0][DW-1:0] lane_data;

  // Row FIFO: wrap bit distinguishes full from empty when the indices match.
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty    = (wptr == rptr);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign head     = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= {in_last, in_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    flush_d   = flush_q;
    pop       = 1'b0;
    shift     = 1'b0;
    under_inc = 1'b0;
    case (state_q)
      IDLE: if (!empty) state_d = STREAM;
      STREAM: begin
        if (en) begin
          shift = 1'b1;
          if (!empty) begin
            pop = 1'b1;
            if (head.last) begin
              if (N == 1) state_d = DONE;
              else begin
                state_d = FLUSH;
                flush_d = CW'(N - 1);
              end
            end
          end else begin
            under_inc = 1'b1;
          end
        end
      end
      // N bubbles in total push the final row past lane N-1.
      FLUSH: begin
        if (en) begin
          shift = 1'b1;
          if (flush_q == '0) state_d = DONE;
          else flush_d = flush_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) underrun <= '0;
    else if (under_inc && underrun != 16'hFFFF) underrun <= underrun + 1'b1;
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign inj_data = pop ? head.data : '0;

  for (genvar i = 0; i < N; i++) begin : g_lane
    sa_lane_delay #(.DW(DW), .STAGES(i + 1)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .en   (shift),
      .din  (inj_data[i]),
      .vin  (pop),
      .dout (lane_data[i]),
      .vout (out_valid[i])
    );
  end

  assign out_data = lane_data;
endmodule
